// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the seven-segment array controller.
//   - word offsets of the Avalon-MM register map
//   - CTRL bit positions
//   - segment width and the hex-to-segment lookup (active-high, bit0=a .. bit6=g)
package seg7_pkg;

    localparam int SEG_W = 7;

    localparam int REG_CTRL       = 0;
    localparam int REG_BLINK_MASK = 1;
    localparam int REG_BLINK_DIV  = 2;
    localparam int REG_STATUS     = 3;
    localparam int DIGIT_BASE     = 4;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_HEX      = 1;
    localparam int CTRL_BLINK_EN = 2;

    function automatic logic [SEG_W-1:0] hex2seg(input logic [3:0] nib);
        logic [SEG_W-1:0] seg;
        case (nib)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational nibble to seven-segment decoder.
//   i_nib  : 4-bit value 0..F
//   o_seg  : active-high segment pattern, bit0=a .. bit6=g
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0]       i_nib,
    output logic [SEG_W-1:0] o_seg
);

    assign o_seg = hex2seg(i_nib);

endmodule

// File: rtl/seg7_array_ctrl.sv
// seg7_array_ctrl: N-digit seven-segment display controller with an
// Avalon-MM slave (read latency 1), raw or hex display, and per-digit blink.
//   csi_clk, csi_reset       : clock, synchronous active-high reset
//   avs_s1_address           : word address (CTRL, BLINK_MASK, BLINK_DIV, STATUS, DIGITn)
//   avs_s1_read/write        : access strobes
//   avs_s1_writedata         : 16-bit write data, gated per byte by avs_s1_byteenable
//   avs_s1_readdata          : registered read data, held until the next read
//   coe_seg                  : registered segment pins, digit k at [7k+6:7k]
module seg7_array_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int ADDR_W         = 5,
    parameter int PRESCALE       = 50000,
    parameter int SEG_ACTIVE_LOW = 1
)
(
    input  logic                        csi_clk,
    input  logic                        csi_reset,
    input  logic [ADDR_W-1:0]           avs_s1_address,
    input  logic                        avs_s1_read,
    input  logic                        avs_s1_write,
    input  logic [15:0]                 avs_s1_writedata,
    input  logic [1:0]                  avs_s1_byteenable,
    output logic [15:0]                 avs_s1_readdata,
    output logic [SEG_W*NUM_DIGITS-1:0] coe_seg
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [2:0]            r_ctrl;
    logic [NUM_DIGITS-1:0] r_mask;
    logic [15:0]           r_div;
    logic [SEG_W-1:0]      r_digit [NUM_DIGITS];
    logic [PS_W-1:0]       r_presc;
    logic [15:0]           r_bcnt;
    logic                  r_phase;
    logic [15:0]           r_rdata;
    logic [SEG_W*NUM_DIGITS-1:0] r_seg;

    logic                  w_wr_any;
    logic                  w_sel_ctrl;
    logic                  w_sel_mask;
    logic                  w_sel_div;
    logic                  w_sel_status;
    logic                  w_wr_div;
    logic                  w_tick;
    logic [15:0]           w_be_bits;
    logic [15:0]           w_rdata;
    logic [SEG_W-1:0]      w_hex [NUM_DIGITS];
    logic [SEG_W*NUM_DIGITS-1:0] w_pat;

    assign w_wr_any     = avs_s1_write && (avs_s1_byteenable != 2'b00);
    assign w_sel_ctrl   = (avs_s1_address == ADDR_W'(REG_CTRL));
    assign w_sel_mask   = (avs_s1_address == ADDR_W'(REG_BLINK_MASK));
    assign w_sel_div    = (avs_s1_address == ADDR_W'(REG_BLINK_DIV));
    assign w_sel_status = (avs_s1_address == ADDR_W'(REG_STATUS));
    assign w_wr_div     = w_wr_any && w_sel_div;
    assign w_be_bits    = {{8{avs_s1_byteenable[1]}}, {8{avs_s1_byteenable[0]}}};
    assign w_tick       = (r_presc == PS_W'(PRESCALE - 1));

    // Register file
    always_ff @(posedge csi_clk) begin
        if (csi_reset) begin
            r_ctrl <= '0;
            r_mask <= '0;
            r_div  <= '0;
            for (int k = 0; k < NUM_DIGITS; k++) begin
                r_digit[k] <= '0;
            end
        end else if (w_wr_any) begin
            if (w_sel_ctrl && avs_s1_byteenable[0]) begin
                r_ctrl <= avs_s1_writedata[2:0];
            end
            if (w_sel_mask) begin
                r_mask <= (r_mask & ~w_be_bits[NUM_DIGITS-1:0])
                        | (avs_s1_writedata[NUM_DIGITS-1:0] & w_be_bits[NUM_DIGITS-1:0]);
            end
            if (w_sel_div) begin
                r_div <= (r_div & ~w_be_bits) | (avs_s1_writedata & w_be_bits);
            end
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (avs_s1_byteenable[0] && avs_s1_address == ADDR_W'(DIGIT_BASE + k)) begin
                    r_digit[k] <= avs_s1_writedata[SEG_W-1:0];
                end
            end
        end
    end

    // Prescaler and blink phase. A BLINK_DIV write restarts the whole
    // period lit so software sees a predictable phase after reprogramming.
    always_ff @(posedge csi_clk) begin
        if (csi_reset || w_wr_div) begin
            r_presc <= '0;
            r_bcnt  <= '0;
            r_phase <= 1'b1;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (r_div == 16'd0) begin
                r_bcnt  <= '0;
                r_phase <= 1'b1;
            end else if (w_tick) begin
                if (r_bcnt == r_div - 16'd1) begin
                    r_bcnt  <= '0;
                    r_phase <= ~r_phase;
                end else begin
                    r_bcnt <= r_bcnt + 16'd1;
                end
            end
        end
    end

    // Read mux samples registers before any same-cycle write lands,
    // so a read/write collision returns the old value.
    always_comb begin
        w_rdata = '0;
        if (w_sel_ctrl) begin
            w_rdata = {13'd0, r_ctrl};
        end else if (w_sel_mask) begin
            w_rdata = 16'(r_mask);
        end else if (w_sel_div) begin
            w_rdata = r_div;
        end else if (w_sel_status) begin
            w_rdata = {3'd0, 5'(NUM_DIGITS), 7'd0, r_phase};
        end
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (avs_s1_address == ADDR_W'(DIGIT_BASE + k)) begin
                w_rdata = {9'd0, r_digit[k]};
            end
        end
    end

    always_ff @(posedge csi_clk) begin
        if (csi_reset) begin
            r_rdata <= '0;
        end else if (avs_s1_read) begin
            r_rdata <= w_rdata;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_DIGITS; g++) begin : g_dec
            seg7_hex_decode u_dec (
                .i_nib (r_digit[g][3:0]),
                .o_seg (w_hex[g])
            );
        end
    endgenerate

    always_comb begin
        w_pat = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_ctrl[CTRL_EN] && !(r_ctrl[CTRL_BLINK_EN] && r_mask[k] && !r_phase)) begin
                w_pat[k*SEG_W +: SEG_W] = r_ctrl[CTRL_HEX] ? w_hex[k] : r_digit[k];
            end
        end
    end

    always_ff @(posedge csi_clk) begin
        if (csi_reset) begin
            r_seg <= (SEG_ACTIVE_LOW != 0) ? '1 : '0;
        end else begin
            r_seg <= (SEG_ACTIVE_LOW != 0) ? ~w_pat : w_pat;
        end
    end

    assign avs_s1_readdata = r_rdata;
    assign coe_seg         = r_seg;

endmodule

// File: tb/tb_seg7_array_ctrl.sv
// Scoreboard bench for seg7_array_ctrl (4 digits, PRESCALE=4, active-low pins).
module tb_seg7_array_ctrl;

    localparam int NUM_DIGITS = 4;
    localparam int ADDR_W     = 5;
    localparam int PRESCALE   = 4;

    logic        csi_clk = 1'b0;
    logic        csi_reset;
    logic [4:0]  avs_s1_address;
    logic        avs_s1_read;
    logic        avs_s1_write;
    logic [15:0] avs_s1_writedata;
    logic [1:0]  avs_s1_byteenable;
    logic [15:0] avs_s1_readdata;
    logic [27:0] coe_seg;

    seg7_array_ctrl #(
        .NUM_DIGITS     (NUM_DIGITS),
        .ADDR_W         (ADDR_W),
        .PRESCALE       (PRESCALE),
        .SEG_ACTIVE_LOW (1)
    ) dut (
        .csi_clk           (csi_clk),
        .csi_reset         (csi_reset),
        .avs_s1_address    (avs_s1_address),
        .avs_s1_read       (avs_s1_read),
        .avs_s1_write      (avs_s1_write),
        .avs_s1_writedata  (avs_s1_writedata),
        .avs_s1_byteenable (avs_s1_byteenable),
        .avs_s1_readdata   (avs_s1_readdata),
        .coe_seg           (coe_seg)
    );

    always #5 csi_clk = ~csi_clk;

    typedef struct {
        int          due;
        logic [27:0] exp;
        string       name;
    } seg_exp_t;

    typedef struct {
        logic [15:0] exp;
        string       name;
    } rd_exp_t;

    seg_exp_t seg_q[$];
    rd_exp_t  rd_q[$];
    seg_exp_t m_seg;
    rd_exp_t  m_rd;

    int   cyc        = 0;
    int   n_vec      = 0;
    int   n_err      = 0;
    logic rd_seen    = 1'b0;
    logic finish_req = 1'b0;
    logic drained    = 1'b0;

    always @(posedge csi_clk) begin
        cyc     <= cyc + 1;
        rd_seen <= avs_s1_read;
    end

    // Monitor: read data the cycle after a read strobe; pins at their due cycle.
    always @(negedge csi_clk) begin
        if (rd_seen) begin
            n_vec++;
            if (rd_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_read: readdata=%h with no expectation", avs_s1_readdata);
            end else begin
                m_rd = rd_q.pop_front();
                if (avs_s1_readdata !== m_rd.exp) begin
                    n_err++;
                    $display("FAIL %s: readdata=%h expected %h", m_rd.name, avs_s1_readdata, m_rd.exp);
                end
            end
        end
        while (seg_q.size() > 0 && seg_q[0].due <= cyc) begin
            m_seg = seg_q.pop_front();
            n_vec++;
            if (m_seg.due < cyc) begin
                n_err++;
                $display("FAIL %s: sample point missed (due %0d, now %0d)", m_seg.name, m_seg.due, cyc);
            end else if (coe_seg !== m_seg.exp) begin
                n_err++;
                $display("FAIL %s: coe_seg=%h expected %h", m_seg.name, coe_seg, m_seg.exp);
            end
        end
        if (finish_req && !drained) begin
            while (rd_q.size() > 0) begin
                m_rd = rd_q.pop_front();
                n_vec++;
                n_err++;
                $display("FAIL %s: read never returned, expected %h", m_rd.name, m_rd.exp);
            end
            while (seg_q.size() > 0) begin
                m_seg = seg_q.pop_front();
                n_vec++;
                n_err++;
                $display("FAIL %s: never sampled, expected %h", m_seg.name, m_seg.exp);
            end
            drained = 1'b1;
        end
    end

    function automatic logic [27:0] pk(input logic [6:0] d3, input logic [6:0] d2,
                                       input logic [6:0] d1, input logic [6:0] d0);
        return {d3, d2, d1, d0};
    endfunction

    task automatic expect_seg(input int due, input logic [27:0] exp, input string name);
        seg_exp_t e;
        e.due  = due;
        e.exp  = exp;
        e.name = name;
        seg_q.push_back(e);
    endtask

    task automatic bus(input logic rd, input logic wr, input logic [4:0] a,
                       input logic [15:0] d, input logic [1:0] be);
        avs_s1_read       = rd;
        avs_s1_write      = wr;
        avs_s1_address    = a;
        avs_s1_writedata  = d;
        avs_s1_byteenable = be;
        @(posedge csi_clk);
        #1;
        avs_s1_read  = 1'b0;
        avs_s1_write = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [15:0] d, input logic [1:0] be);
        bus(1'b0, 1'b1, a, d, be);
    endtask

    task automatic rd(input logic [4:0] a, input logic [15:0] exp, input string name);
        rd_exp_t e;
        e.exp  = exp;
        e.name = name;
        rd_q.push_back(e);
        bus(1'b1, 1'b0, a, 16'h0000, 2'b00);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge csi_clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        int w2;
        csi_reset         = 1'b1;
        avs_s1_read       = 1'b0;
        avs_s1_write      = 1'b0;
        avs_s1_address    = '0;
        avs_s1_writedata  = '0;
        avs_s1_byteenable = '0;
        repeat (3) @(posedge csi_clk);
        #1;
        expect_seg(cyc, 28'hFFFFFFF, "reset_pins");
        csi_reset = 1'b0;
        rd(5'd3, 16'h0401, "reset_status");
        rd(5'd0, 16'h0000, "reset_ctrl");

        // Raw mode
        wr(5'd0, 16'h0001, 2'b11);
        expect_seg(cyc + 1, 28'hFFFFFFF, "raw_en_zero_digits");
        wr(5'd4, 16'h003F, 2'b01);
        expect_seg(cyc + 1, pk(7'h7F, 7'h7F, 7'h7F, 7'h40), "raw_digit0");
        wr(5'd7, 16'h0006, 2'b01);
        expect_seg(cyc + 1, pk(7'h79, 7'h7F, 7'h7F, 7'h40), "raw_digit3");
        rd(5'd4, 16'h003F, "raw_digit0_readback");

        // Hex mode
        wr(5'd0, 16'h0003, 2'b11);
        expect_seg(cyc + 1, pk(7'h02, 7'h40, 7'h40, 7'h0E), "hex_switch");
        wr(5'd5, 16'h00FA, 2'b11);
        expect_seg(cyc + 1, pk(7'h02, 7'h40, 7'h08, 7'h0E), "hex_digit1_A");
        rd(5'd5, 16'h007A, "hex_digit1_readback");

        // Byteenable and unmapped addresses
        wr(5'd2, 16'hABCD, 2'b10);
        rd(5'd2, 16'hAB00, "div_be_upper_only");
        wr(5'd31, 16'hFFFF, 2'b11);
        rd(5'd31, 16'h0000, "unmapped_read");
        rd(5'd0, 16'h0003, "ctrl_after_unmapped");
        rd(5'd1, 16'h0000, "mask_after_unmapped");
        wr(5'd0, 16'h0000, 2'b00);
        rd(5'd0, 16'h0003, "ctrl_be00_noop");
        wr(5'd3, 16'hFFFF, 2'b11);
        rd(5'd3, 16'h0401, "status_readonly");

        // Read/write collision on DIGIT2
        begin
            rd_exp_t e;
            e.exp  = 16'h0000;
            e.name = "collision_old_value";
            rd_q.push_back(e);
        end
        bus(1'b1, 1'b1, 5'd6, 16'h0005, 2'b11);
        expect_seg(cyc + 1, pk(7'h02, 7'h12, 7'h08, 7'h0E), "collision_write_pins");
        rd(5'd6, 16'h0005, "collision_new_value");

        // Blink: digit0 shows 8 (all lit), toggles every 12 clocks
        wr(5'd1, 16'h0001, 2'b11);
        wr(5'd4, 16'h0008, 2'b01);
        expect_seg(cyc + 1, pk(7'h02, 7'h12, 7'h08, 7'h00), "hex_digit0_8");
        wr(5'd2, 16'h0003, 2'b11);
        w = cyc;
        wr(5'd0, 16'h0007, 2'b01);
        expect_seg(w + 12, pk(7'h02, 7'h12, 7'h08, 7'h00), "blink_lit_end");
        expect_seg(w + 13, pk(7'h02, 7'h12, 7'h08, 7'h7F), "blink_dark_start");
        expect_seg(w + 24, pk(7'h02, 7'h12, 7'h08, 7'h7F), "blink_dark_end");
        expect_seg(w + 25, pk(7'h02, 7'h12, 7'h08, 7'h00), "blink_lit_again");
        wait_cyc(w + 13);
        rd(5'd3, 16'h0400, "status_phase0");
        wait_cyc(w + 25);
        rd(5'd3, 16'h0401, "status_phase1");

        // BLINK_DIV rewrite while dark forces lit and restarts the period
        wait_cyc(w + 39);
        wr(5'd2, 16'h0003, 2'b11);
        w2 = cyc;
        expect_seg(w2,      pk(7'h02, 7'h12, 7'h08, 7'h7F), "rewrite_prior_dark");
        expect_seg(w2 + 1,  pk(7'h02, 7'h12, 7'h08, 7'h00), "rewrite_forces_lit");
        expect_seg(w2 + 12, pk(7'h02, 7'h12, 7'h08, 7'h00), "rewrite_lit_full_period");
        expect_seg(w2 + 13, pk(7'h02, 7'h12, 7'h08, 7'h7F), "rewrite_restart_dark");
        expect_seg(w2 + 14, pk(7'h02, 7'h12, 7'h08, 7'h7F), "pre_reset_dark");

        // Reset during blink-off
        wait_cyc(w2 + 14);
        csi_reset = 1'b1;
        @(posedge csi_clk);
        #1;
        csi_reset = 1'b0;
        expect_seg(cyc, 28'hFFFFFFF, "reset_mid_blink_pins");
        rd(5'd3, 16'h0401, "status_after_reset");
        rd(5'd0, 16'h0000, "ctrl_after_reset");
        rd(5'd2, 16'h0000, "div_after_reset");
        rd(5'd5, 16'h0000, "digit1_after_reset");
        expect_seg(cyc + 3, 28'hFFFFFFF, "dark_after_reset");

        repeat (6) @(posedge csi_clk);
        #1;
        finish_req = 1'b1;
        repeat (2) @(posedge csi_clk);
        #1;
        if (!drained) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: monitor did not finish");
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
